// File: rtl/fifo_pkg.sv
// Shared definitions for the 8-entry asynchronous FIFO pointer controllers.
// Both the write-side (wptr_full_3) and read-side (rptr_empty_3) controllers
// import this package so the Gray encoding is identical on both sides.
package fifo_pkg;

    // RAM address width of the FIFO; pointers carry one extra wrap bit.
    localparam int FIFO_ADDR_W = 3;
    localparam int FIFO_PTR_W  = FIFO_ADDR_W + 1;

    // Conversion helpers operate on a fixed wide vector. Callers zero-extend
    // their pointer into it and truncate the result back. Zero upper bits do
    // not disturb either conversion, so one function serves any width.
    localparam int GRAY_MAX_W = 16;

    // Binary to reflected Gray code.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = '0;
        for (int i = 0; i < GRAY_MAX_W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_full_3.sv
// Write-side pointer controller for the 8-entry asynchronous FIFO.
// Counts accepted pushes, drives the RAM write address, and publishes a
// registered Gray write pointer to the read-domain synchronizer. Full,
// almost-full and occupancy are computed against the already-synchronized
// Gray read pointer, so they may overstate occupancy but never understate it.
//
// Handshake: push is the producer's request; a word is written into the RAM
// at waddr in exactly the cycles where w_ack = push & ~wfull is high. A push
// seen while wfull=1 is dropped (no pointer movement) and sets overflow.
module wptr_full_3
    import fifo_pkg::*;
#(
    parameter int ADDR_W       = FIFO_ADDR_W,
    parameter int AFULL_THRESH = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W:0]   wq2_rptr,
    output logic              w_ack,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W:0]   wptr,
    output logic              wfull,
    output logic              walmost_full,
    output logic [ADDR_W:0]   wcount,
    output logic              overflow
);

    localparam int PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0] wbin_q,   wbin_d;
    logic [PTR_W-1:0] wptr_q,   wptr_d;
    logic [PTR_W-1:0] wcount_q, wcount_d;
    logic             wfull_q,  wfull_d;
    logic             afull_q,  afull_d;
    logic             ovf_q,    ovf_d;

    logic             ack;
    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] full_pattern;

    // Next-state: advance on accepted push, re-derive flags from the next pointer
    // and the current synchronized read pointer in the same cycle.
    always_comb begin
        ack          = push & ~wfull_q;
        wbin_d       = wbin_q + PTR_W'(ack);
        wptr_d       = PTR_W'(bin2gray(GRAY_MAX_W'(wbin_d)));
        rbin         = PTR_W'(gray2bin(GRAY_MAX_W'(wq2_rptr)));
        // Full when the write pointer is exactly one lap ahead of the read
        // pointer; in Gray code that means the top two bits differ and the
        // rest match.
        full_pattern = {~wq2_rptr[ADDR_W:ADDR_W-1], wq2_rptr[ADDR_W-2:0]};
        wfull_d      = (wptr_d == full_pattern);
        wcount_d     = wbin_d - rbin;
        afull_d      = (wcount_d >= PTR_W'(AFULL_THRESH));
        ovf_d        = ovf_q | (push & wfull_q);
    end

    // State registers, cleared asynchronously together with the read side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wcount_q <= '0;
            wfull_q  <= 1'b0;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wcount_q <= wcount_d;
            wfull_q  <= wfull_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
        end
    end

    assign w_ack        = ack;
    assign waddr        = wbin_q[ADDR_W-1:0];
    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign walmost_full = afull_q;
    assign wcount       = wcount_q;
    assign overflow     = ovf_q;

endmodule
